// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared types and constants for the issue stage
package issue_pkg;

  localparam int ISS_CTRL_W = 31;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_SRA = 6'h03;

  // Field order is the iss_ex_ctrl bit layout, MSB first.
  typedef struct packed {
    logic       selalushift;
    logic       selimregb;
    logic [2:0] aluop;
    logic       unsig;
    logic [1:0] shiftop;
    logic       readmem;
    logic       writemem;
    logic       selwsource;
    logic       writereg;
    logic       writeov;
    logic       selregdest;
    logic [4:0] regdest;
    logic [5:0] op;
    logic [5:0] funct;
  } iss_ctrl_t;

  // Immediate shifts take their shift amount from the bundle, not from rs.
  function automatic logic uses_rs(input iss_ctrl_t c);
    return !(c.selalushift && c.op == 6'd0 && c.funct[5:2] == 4'd0);
  endfunction

  function automatic logic uses_rt(input iss_ctrl_t c);
    return !c.selimregb || c.writemem;
  endfunction

endpackage

// File: rtl/issue_stage_if.sv
// rtl/issue_stage_if.sv - decode, writeback and dispatch signals around the issue stage
interface issue_stage_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
);
  import issue_pkg::*;

  logic              id_iss_selalushift, id_iss_selimregb, id_iss_unsig;
  logic              id_iss_readmem, id_iss_writemem, id_iss_selwsource;
  logic              id_iss_writereg, id_iss_writeov, id_iss_selregdest;
  logic [2:0]        id_iss_aluop;
  logic [1:0]        id_iss_shiftop;
  logic [4:0]        id_iss_regdest, id_iss_addra, id_iss_addrb;
  logic [5:0]        id_iss_op, id_iss_funct;
  logic [DATA_W-1:0] id_iss_imedext, id_iss_dataa, id_iss_datab;
  logic              iss_stall;

  logic              wb_iss_writereg;
  logic [4:0]        wb_iss_regdest;
  logic [DATA_W-1:0] wb_iss_data;

  logic              alu_iss_ready, mem_iss_ready;
  logic              iss_alu_valid, iss_mem_valid;
  logic [DATA_W-1:0] iss_ex_dataa, iss_ex_datab, iss_ex_imedext;
  logic [ISS_CTRL_W-1:0] iss_ex_ctrl;

  modport master (
    output id_iss_selalushift, id_iss_selimregb, id_iss_unsig, id_iss_readmem,
           id_iss_writemem, id_iss_selwsource, id_iss_writereg, id_iss_writeov,
           id_iss_selregdest, id_iss_aluop, id_iss_shiftop, id_iss_regdest,
           id_iss_addra, id_iss_addrb, id_iss_op, id_iss_funct, id_iss_imedext,
           id_iss_dataa, id_iss_datab, wb_iss_writereg, wb_iss_regdest,
           wb_iss_data, alu_iss_ready, mem_iss_ready,
    input  iss_stall, iss_alu_valid, iss_mem_valid, iss_ex_dataa,
           iss_ex_datab, iss_ex_imedext, iss_ex_ctrl
  );

  modport slave (
    input  id_iss_selalushift, id_iss_selimregb, id_iss_unsig, id_iss_readmem,
           id_iss_writemem, id_iss_selwsource, id_iss_writereg, id_iss_writeov,
           id_iss_selregdest, id_iss_aluop, id_iss_shiftop, id_iss_regdest,
           id_iss_addra, id_iss_addrb, id_iss_op, id_iss_funct, id_iss_imedext,
           id_iss_dataa, id_iss_datab, wb_iss_writereg, wb_iss_regdest,
           wb_iss_data, alu_iss_ready, mem_iss_ready,
    output iss_stall, iss_alu_valid, iss_mem_valid, iss_ex_dataa,
           iss_ex_datab, iss_ex_imedext, iss_ex_ctrl
  );

endinterface

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - per-register pending bits for in-flight destinations
module issue_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  input  logic [AW-1:0] rd_addr_d,
  output logic          pend_a,
  output logic          pend_b,
  output logic          pend_d
);

  logic [NREG-1:0] pend;

  // The set is written last so a same-cycle set and clear leaves the bit set.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend <= '0;
    end else begin
      if (clr_en && clr_addr != '0) pend[clr_addr] <= 1'b0;
      if (set_en && set_addr != '0) pend[set_addr] <= 1'b1;
    end
  end

  assign pend_a = pend[rd_addr_a];
  assign pend_b = pend[rd_addr_b];
  assign pend_d = pend[rd_addr_d];

endmodule

// File: rtl/issue_stage.sv
// rtl/issue_stage.sv - single-entry in-order issue with scoreboard and writeback refresh
module issue_stage
  import issue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input logic          clock,
  input logic          reset,
  issue_stage_if.slave bus
);

  iss_ctrl_t         in_ctrl, h_ctrl;
  logic              h_v;
  logic [4:0]        h_addra, h_addrb;
  logic [DATA_W-1:0] h_dataa, h_datab, h_imed;
  logic              pend_a, pend_b, pend_d;
  logic              wb_hit_a, wb_hit_b, in_hit_a, in_hit_b;
  logic              src_ok_a, src_ok_b, dest_ok, is_mem, tgt_rdy, fire, stall;

  function automatic logic wb_hit(input logic we, input logic [4:0] wr, input logic [4:0] a);
    return we && wr == a && a != 5'd0;
  endfunction

  assign in_ctrl = '{
    selalushift: bus.id_iss_selalushift, selimregb: bus.id_iss_selimregb,
    aluop: bus.id_iss_aluop, unsig: bus.id_iss_unsig, shiftop: bus.id_iss_shiftop,
    readmem: bus.id_iss_readmem, writemem: bus.id_iss_writemem,
    selwsource: bus.id_iss_selwsource, writereg: bus.id_iss_writereg,
    writeov: bus.id_iss_writeov, selregdest: bus.id_iss_selregdest,
    regdest: bus.id_iss_regdest, op: bus.id_iss_op, funct: bus.id_iss_funct
  };

  assign wb_hit_a = wb_hit(bus.wb_iss_writereg, bus.wb_iss_regdest, h_addra);
  assign wb_hit_b = wb_hit(bus.wb_iss_writereg, bus.wb_iss_regdest, h_addrb);
  assign in_hit_a = wb_hit(bus.wb_iss_writereg, bus.wb_iss_regdest, bus.id_iss_addra);
  assign in_hit_b = wb_hit(bus.wb_iss_writereg, bus.wb_iss_regdest, bus.id_iss_addrb);

  assign src_ok_a = !uses_rs(h_ctrl) || !pend_a || wb_hit_a;
  assign src_ok_b = !uses_rt(h_ctrl) || !pend_b || wb_hit_b;
  assign dest_ok  = !h_ctrl.writereg || !pend_d;
  assign is_mem   = h_ctrl.readmem || h_ctrl.writemem;
  assign tgt_rdy  = is_mem ? bus.mem_iss_ready : bus.alu_iss_ready;
  assign fire     = h_v && src_ok_a && src_ok_b && dest_ok && tgt_rdy;
  assign stall    = h_v && !fire;

  // Decode's operands were read before this cycle's writeback landed in the
  // register file, so a matching writeback is forwarded on load as well.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_v     <= 1'b0;
      h_ctrl  <= '0;
      h_addra <= '0;
      h_addrb <= '0;
      h_dataa <= '0;
      h_datab <= '0;
      h_imed  <= '0;
    end else if (!stall) begin
      h_v     <= bus.id_iss_writereg || bus.id_iss_readmem || bus.id_iss_writemem;
      h_ctrl  <= in_ctrl;
      h_addra <= bus.id_iss_addra;
      h_addrb <= bus.id_iss_addrb;
      h_dataa <= in_hit_a ? bus.wb_iss_data : bus.id_iss_dataa;
      h_datab <= in_hit_b ? bus.wb_iss_data : bus.id_iss_datab;
      h_imed  <= bus.id_iss_imedext;
    end else begin
      if (wb_hit_a) h_dataa <= bus.wb_iss_data;
      if (wb_hit_b) h_datab <= bus.wb_iss_data;
    end
  end

  issue_scoreboard #(.NREG(NREG)) u_sb (
    .clock     (clock),
    .reset     (reset),
    .set_en    (fire && h_ctrl.writereg),
    .set_addr  (h_ctrl.regdest),
    .clr_en    (bus.wb_iss_writereg),
    .clr_addr  (bus.wb_iss_regdest),
    .rd_addr_a (h_addra),
    .rd_addr_b (h_addrb),
    .rd_addr_d (h_ctrl.regdest),
    .pend_a    (pend_a),
    .pend_b    (pend_b),
    .pend_d    (pend_d)
  );

  assign bus.iss_stall      = stall;
  assign bus.iss_alu_valid  = fire && !is_mem;
  assign bus.iss_mem_valid  = fire && is_mem;
  assign bus.iss_ex_dataa   = wb_hit_a ? bus.wb_iss_data : h_dataa;
  assign bus.iss_ex_datab   = wb_hit_b ? bus.wb_iss_data : h_datab;
  assign bus.iss_ex_imedext = h_imed;
  assign bus.iss_ex_ctrl    = h_ctrl;

endmodule

// File: tb/tb_issue_stage.sv
// tb/tb_issue_stage.sv - directed and randomized checks of issue_stage against a reference model
module tb_issue_stage;
  import issue_pkg::*;

  typedef struct packed {
    logic       selalushift, selimregb;
    logic [2:0] aluop;
    logic       unsig;
    logic [1:0] shiftop;
    logic       readmem, writemem, selwsource, writereg, writeov, selregdest;
    logic [4:0] regdest, addra, addrb;
    logic [5:0] op, funct;
    logic [31:0] imed;
  } instr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  issue_stage_if #(.DATA_W(32), .NREG(32)) bus ();
  issue_stage #(.DATA_W(32), .NREG(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] arf [32];
  bit          pend_m [32];
  bit          hv_m;
  bit          dec_take;
  instr_t      h_m, dec;
  instr_t      prog [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [30:0] ctrl_of(input instr_t i);
    return {i.selalushift, i.selimregb, i.aluop, i.unsig, i.shiftop, i.readmem,
            i.writemem, i.selwsource, i.writereg, i.writeov, i.selregdest,
            i.regdest, i.op, i.funct};
  endfunction

  function automatic instr_t mk_alu(input logic [5:0] fn, input logic [4:0] rd, rs, rt);
    instr_t i = '0;
    i.writereg = 1; i.selregdest = 1; i.aluop = 3'd2; i.funct = fn;
    i.regdest = rd; i.addra = rs; i.addrb = rt;
    return i;
  endfunction

  function automatic instr_t mk_shift(input logic [5:0] fn, input logic [4:0] rd, rs, rt, input logic [4:0] sh);
    instr_t i = mk_alu(fn, rd, rs, rt);
    i.selalushift = 1; i.aluop = 3'd0; i.shiftop = fn[1:0]; i.imed = {27'd0, sh};
    return i;
  endfunction

  function automatic instr_t mk_mem(input bit load, input logic [4:0] rt, base, input logic [31:0] off);
    instr_t i = '0;
    i.selimregb = 1; i.addra = base; i.imed = off;
    if (load) begin
      i.readmem = 1; i.writereg = 1; i.selwsource = 1; i.op = 6'h23; i.regdest = rt;
    end else begin
      i.writemem = 1; i.op = 6'h2b; i.addrb = rt;
    end
    return i;
  endfunction

  function automatic instr_t mk_rand();
    instr_t i;
    logic [4:0] rd = 5'($urandom_range(0, 7));
    logic [4:0] rs = 5'($urandom_range(0, 7));
    logic [4:0] rt = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 6))
      0: i = mk_alu(6'h20, rd, rs, rt);
      1: i = mk_shift(6'($urandom_range(0, 3)), rd, rs, rt, 5'($urandom));
      2: i = mk_shift(6'($urandom_range(4, 7)), rd, rs, rt, 5'd0);
      3: begin i = mk_alu(6'h00, rd, rs, 5'd0); i.selimregb = 1; i.op = 6'h08; i.imed = $urandom; end
      4: i = mk_mem(1'b1, rd, rs, $urandom);
      5: i = mk_mem(1'b0, rt, rs, $urandom);
      default: begin i = '0; if ($urandom_range(0, 1) == 1) begin i.op = 6'h04; i.addra = rs; i.addrb = rt; end end
    endcase
    return i;
  endfunction

  task automatic drive(input bit we, input logic [4:0] wr, input logic [31:0] wd, input bit ar, input bit mr);
    bus.id_iss_selalushift = dec.selalushift; bus.id_iss_selimregb = dec.selimregb;
    bus.id_iss_aluop = dec.aluop; bus.id_iss_unsig = dec.unsig; bus.id_iss_shiftop = dec.shiftop;
    bus.id_iss_readmem = dec.readmem; bus.id_iss_writemem = dec.writemem;
    bus.id_iss_selwsource = dec.selwsource; bus.id_iss_writereg = dec.writereg;
    bus.id_iss_writeov = dec.writeov; bus.id_iss_selregdest = dec.selregdest;
    bus.id_iss_regdest = dec.regdest; bus.id_iss_addra = dec.addra; bus.id_iss_addrb = dec.addrb;
    bus.id_iss_op = dec.op; bus.id_iss_funct = dec.funct; bus.id_iss_imedext = dec.imed;
    bus.id_iss_dataa = arf[dec.addra]; bus.id_iss_datab = arf[dec.addrb];
    bus.wb_iss_writereg = we; bus.wb_iss_regdest = wr; bus.wb_iss_data = wd;
    bus.alu_iss_ready = ar; bus.mem_iss_ready = mr;
  endtask

  // One clock: present decode and writeback, check outputs at the falling edge, then advance the model.
  task automatic tick(input bit we, input logic [4:0] wr, input logic [31:0] wd, input bit ar, input bit mr);
    bit mem, ua, ub, hit_a, hit_b, ok_a, ok_b, ok_d, fire;
    logic [31:0] pv;
    if (dec_take) begin
      if (prog.size() != 0) dec = prog.pop_front();
      else dec = '0;
    end
    drive(we, wr, wd, ar, mr);
    @(negedge clock);
    mem   = h_m.readmem || h_m.writemem;
    ua    = !(h_m.selalushift && h_m.op == 6'd0 && h_m.funct < 6'd4);
    ub    = !h_m.selimregb || h_m.writemem;
    hit_a = we && wr == h_m.addra && h_m.addra != 0;
    hit_b = we && wr == h_m.addrb && h_m.addrb != 0;
    ok_a  = !ua || !pend_m[h_m.addra] || hit_a;
    ok_b  = !ub || !pend_m[h_m.addrb] || hit_b;
    ok_d  = !h_m.writereg || !pend_m[h_m.regdest];
    fire  = hv_m && ok_a && ok_b && ok_d && (mem ? mr : ar);
    for (int r = 0; r < 32; r++) pv[r] = pend_m[r];
    chk("alu_valid", 64'(bus.iss_alu_valid), 64'(fire && !mem));
    chk("mem_valid", 64'(bus.iss_mem_valid), 64'(fire && mem));
    chk("stall", 64'(bus.iss_stall), 64'(hv_m && !fire));
    chk("ctrl", 64'(bus.iss_ex_ctrl), 64'(ctrl_of(h_m)));
    chk("dataa", 64'(bus.iss_ex_dataa), 64'(hit_a ? wd : arf[h_m.addra]));
    chk("datab", 64'(bus.iss_ex_datab), 64'(hit_b ? wd : arf[h_m.addrb]));
    chk("imedext", 64'(bus.iss_ex_imedext), 64'(h_m.imed));
    chk("pend", 64'(dut.u_sb.pend), 64'(pv));
    @(posedge clock);
    if (we && wr != 0) begin pend_m[wr] = 0; arf[wr] = wd; end
    if (fire && h_m.writereg && h_m.regdest != 0) pend_m[h_m.regdest] = 1;
    dec_take = !(hv_m && !fire);
    if (dec_take) begin
      h_m  = dec;
      hv_m = dec.writereg || dec.readmem || dec.writemem;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dec = '0;
    prog.delete();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    @(posedge clock);
    hv_m = 0; h_m = '0; dec_take = 1;
    for (int r = 0; r < 32; r++) pend_m[r] = 0;
    #1 reset = 1'b0;
  endtask

  initial begin
    bit we;
    logic [4:0] wr;
    int pl [$];
    arf[0] = 32'd0;
    for (int r = 1; r < 32; r++) arf[r] = 32'h1000 + 32'(r * 17);
    do_reset();

    repeat (4) tick(0, 0, 0, 1, 1);

    prog.push_back(mk_alu(6'h20, 5'd3, 5'd1, 5'd2));
    prog.push_back(mk_alu(6'h20, 5'd4, 5'd3, 5'd1));
    repeat (4) tick(0, 0, 0, 1, 1);
    tick(1, 5'd3, 32'h55, 1, 1);
    tick(1, 5'd4, 32'h66, 1, 1);

    prog.push_back(mk_mem(1'b1, 5'd5, 5'd1, 32'd8));
    tick(0, 0, 0, 1, 0);
    repeat (3) tick(0, 0, 0, 1, 0);
    repeat (2) tick(0, 0, 0, 1, 1);
    tick(1, 5'd5, 32'habc, 1, 1);

    prog.push_back(mk_alu(6'h20, 5'd0, 5'd1, 5'd2));
    prog.push_back(mk_alu(6'h20, 5'd1, 5'd0, 5'd0));
    prog.push_back(mk_alu(6'h20, 5'd7, 5'd1, 5'd2));
    prog.push_back(mk_shift(FUNCT_SLL, 5'd2, 5'd7, 5'd0, 5'd4));
    prog.push_back(mk_shift(6'h06, 5'd2, 5'd7, 5'd0, 5'd0));
    tick(1, 5'd0, 32'hdead, 1, 1);
    repeat (6) tick(1, 5'd0, 32'hbeef, 1, 1);
    tick(1, 5'd7, 32'h77, 1, 1);
    repeat (2) tick(1, 5'd1, 32'h11, 1, 1);
    tick(1, 5'd2, 32'h22, 1, 1);

    prog.push_back(mk_alu(6'h20, 5'd6, 5'd1, 5'd1));
    prog.push_back(mk_alu(6'h20, 5'd6, 5'd1, 5'd1));
    tick(0, 0, 0, 1, 1);
    tick(1, 5'd6, 32'h600, 1, 1);
    repeat (3) tick(0, 0, 0, 1, 1);
    tick(1, 5'd6, 32'h601, 1, 1);
    repeat (2) tick(0, 0, 0, 1, 1);
    tick(1, 5'd6, 32'h602, 1, 1);

    prog.push_back(mk_alu(6'h20, 5'd3, 5'd1, 5'd2));
    prog.push_back(mk_alu(6'h20, 5'd4, 5'd3, 5'd1));
    repeat (4) tick(0, 0, 0, 1, 1);
    do_reset();
    repeat (2) tick(0, 0, 0, 1, 1);

    for (int c = 0; c < 1500; c++) begin
      if (prog.size() < 2) prog.push_back(mk_rand());
      pl.delete();
      for (int r = 1; r < 32; r++) if (pend_m[r]) pl.push_back(r);
      we = 0; wr = 0;
      if (pl.size() != 0 && $urandom_range(0, 99) < 45) begin
        we = 1; wr = 5'(pl[$urandom_range(0, pl.size() - 1)]);
      end else if ($urandom_range(0, 9) == 0) begin
        we = 1; wr = 5'($urandom_range(0, 7));
      end
      tick(we, wr, $urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
